gba_save_sync: RTL and testbench
================================

# gba_save_sync

Downstream consumer of the EEPROM save store: tracks which 64-byte pages of the 8 KB EEPROM image have been written by the game, waits for a quiet period after the last write, then reads each dirty page through the EEPROM's 8-bit RV-side port and streams it out as a framed byte packet. The stream feeds the save-writeback path to the SD card, through the RV companion CPU.

## Interface
- QUIET_CYCLES, default 1_000_000: idle cycles after the last EEPROM write before a flush may start; minimum 2.
- HDR_MAGIC, default 8'hA5: first byte of every packet.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- written  in  1  one-cycle pulse from the EEPROM when a 64-bit block write completes.
- wr_block  in  10  block index (8-byte units) of that write; sampled only while written=1.
- model  in  1  0: 512-byte EEPROM (pages 0..7 valid), 1: 8 KB (pages 0..127).
- flush_now  in  1  pulse; skip the remaining quiet time and flush immediately if any page is dirty.
- rv_rd  out  1  read strobe to the EEPROM RV port.
- rv_addr  out  13  byte address to the EEPROM RV port.
- rv_rdata  in  8  read data, valid exactly one cycle after rv_rd.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  8  stream byte.
- out_last  out  1  marks the final byte of a packet.
- busy  out  1  high from packet start until the flush ends.
- dirty_any  out  1  OR of the dirty bitmap.

## Operation
- Dirty bitmap: 128 bits; page = wr_block[9:3]. A written pulse sets bit page. When model=0, wr_block[9:6] is ignored (page = {4'b0, wr_block[5:3]}).
- Quiet counter: cleared by every written pulse; otherwise increments and saturates at QUIET_CYCLES. flush_now forces it to saturate.
- States:
  - IDLE: leave when dirty_any and the counter is saturated -> SCAN.
  - SCAN: select the lowest-index set bit, clear it, latch the page, set busy -> HDR0.
  - HDR0: send HDR_MAGIC.
  - HDR1: send {1'b0, page}.
  - RD: assert rv_rd with rv_addr={page,off}.
  - CAP: register rv_rdata into out_data.
  - SEND: hold until accepted. off=63 sets out_last. After acceptance, off<63 -> RD, else -> NEXT.
  - NEXT: if dirty_any and no written pulse arrived since this packet's SCAN -> SCAN; else busy=0 -> IDLE. The quiet wait re-arms in IDLE.
- Packet: 66 bytes (magic, page, 64 data bytes in ascending address order). out_last is set only on data byte 63.
- Set/clear collision: a written pulse for the page being cleared in the same SCAN cycle leaves the bit set.
- A write to a page already being streamed re-sets its bit; the page is re-sent in a later flush. A packet in flight is never aborted.
- If model=0 and bits 8..127 are set, they are still flushed; page indices are never masked on output.

## Timing
- Reset values: all outputs 0; bitmap 0; counter 0; off 0; state IDLE.
- Flush start: a written pulse at cycle t with no later writes puts the FSM in SCAN at t+QUIET_CYCLES+1, and HDR0 out_valid at t+QUIET_CYCLES+2.
- Stream handshake: a byte transfers on out_valid & out_ready. out_valid, out_data and out_last stay stable until accepted; out_valid never drops without a transfer.
- Read: rv_rd is a one-cycle pulse; data is captured in the following cycle.
- Throughput with out_ready held high: 3 cycles per data byte (RD, CAP, SEND); full page = 2+192 cycles plus SCAN.
- Reset mid-packet: the stream ends immediately with no out_last, and the bitmap is lost. The consumer must discard any partial packet.

## Structure
- Shared package gba_save_pkg:
  - state enum.
  - PAGE_BYTES=64, PAGES=128.
  - Default HDR_MAGIC.
- Sub-module prio_enc128: combinational lowest-set-bit finder, outputs index[6:0] and found.

## Test plan
- QUIET_CYCLES=16; written with wr_block=10'h009; out_ready=1 -> packet A5,01 then bytes 0x40..0x7F, out_last on the 66th byte; SCAN at t+17.
- written to blocks 0x3F8 and 0x000 -> two packets, page 0x00 first, then 0x7F.
- out_ready toggled randomly -> no byte lost or duplicated; data stable while stalled.
- written for the page being streamed, mid-packet -> current packet finishes; after 16 quiet cycles the same page is re-sent.
- written and SCAN of the same page in one cycle -> bit remains set; dirty_any=1 after SCAN.
- model=0, wr_block=10'h3F8 -> page 0x07 flushed. rst asserted mid-packet -> outputs 0 asynchronously, dirty_any=0.

Source files
------------

// File: rtl/gba_save_pkg.sv
// Shared types and constants for the EEPROM save-page flush engine.
package gba_save_pkg;
  localparam int PAGE_BYTES = 64;
  localparam int PAGES      = 128;
  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_HDR0, ST_HDR1, ST_RD, ST_CAP, ST_SEND, ST_NEXT
  } state_t;

  // The 512-byte part only decodes block bits [5:0], so higher bits alias.
  function automatic logic [6:0] page_of(input logic [9:0] blk, input logic model);
    return model ? blk[9:3] : {4'b0, blk[5:3]};
  endfunction
endpackage

// File: rtl/gba_save_sync_if.sv
// EEPROM RV read port plus the outgoing byte stream.
interface gba_save_sync_if;
  logic        rv_rd;
  logic [12:0] rv_addr;
  logic [7:0]  rv_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (output rv_rd, rv_addr, out_valid, out_data, out_last,
                  input  rv_rdata, out_ready);
  modport slave  (input  rv_rd, rv_addr, out_valid, out_data, out_last,
                  output rv_rdata, out_ready);
endinterface

// File: rtl/gba_save_sync_prio_enc128.sv
// Combinational lowest-set-bit finder over the dirty-page bitmap.
module prio_enc128
  import gba_save_pkg::*;
(
  input  logic [PAGES-1:0] vec,
  output logic [6:0]       index,
  output logic             found
);
  always_comb begin
    index = '0;
    for (int i = PAGES - 1; i >= 0; i--)
      if (vec[i]) index = 7'(i);
  end

  assign found = |vec;
endmodule

// File: rtl/gba_save_sync.sv
// Tracks dirty EEPROM pages and, after a quiet period, streams each one out
// as a framed packet: magic, page index, then 64 bytes read through the RV port.
module gba_save_sync
  import gba_save_pkg::*;
#(
  parameter int         QUIET_CYCLES = 1_000_000,
  parameter logic [7:0] HDR_MAGIC    = HDR_MAGIC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  written,
  input  logic [9:0]            wr_block,
  input  logic                  model,
  input  logic                  flush_now,
  gba_save_sync_if.master       bus,
  output logic                  busy,
  output logic                  dirty_any
);
  localparam int              CW       = $clog2(QUIET_CYCLES + 1);
  localparam logic [CW-1:0]   QMAX     = CW'(QUIET_CYCLES);
  localparam logic [5:0]      LAST_OFF = 6'(PAGE_BYTES - 1);

  state_t           state;
  logic [PAGES-1:0] dirty;
  logic [PAGES-1:0] set_mask, clr_mask;
  logic [CW-1:0]    quiet, quiet_nxt;
  logic [6:0]       page, pick;
  logic [5:0]       off;
  logic             found, wr_seen, go;

  prio_enc128 u_prio (.vec(dirty), .index(pick), .found(found));

  assign dirty_any = found;
  assign set_mask  = written ? (PAGES'(1) << page_of(wr_block, model)) : '0;
  assign clr_mask  = (state == ST_SCAN) ? (PAGES'(1) << pick) : '0;

  always_comb begin
    quiet_nxt = quiet;
    if (flush_now)          quiet_nxt = QMAX;
    else if (written)       quiet_nxt = '0;
    else if (quiet != QMAX) quiet_nxt = quiet + 1'b1;
  end

  // Deciding on the upcoming count lets SCAN land in the cycle saturation is reached.
  assign go = found && (quiet_nxt == QMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty <= '0;
      quiet <= '0;
    end else begin
      // Set after clear: a write racing the SCAN of its own page keeps the bit.
      dirty <= (dirty & ~clr_mask) | set_mask;
      quiet <= quiet_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      page          <= '0;
      off           <= '0;
      wr_seen       <= 1'b0;
      busy          <= 1'b0;
      bus.rv_rd     <= 1'b0;
      bus.rv_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (written) wr_seen <= 1'b1;
      case (state)
        ST_IDLE: if (go) state <= ST_SCAN;
        ST_SCAN: begin
          page          <= pick;
          off           <= '0;
          busy          <= 1'b1;
          wr_seen       <= written;
          bus.out_valid <= 1'b1;
          bus.out_data  <= HDR_MAGIC;
          state         <= ST_HDR0;
        end
        ST_HDR0: if (bus.out_ready) begin
          bus.out_data <= {1'b0, page};
          state        <= ST_HDR1;
        end
        ST_HDR1: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.rv_rd     <= 1'b1;
          bus.rv_addr   <= {page, off};
          state         <= ST_RD;
        end
        ST_RD: begin
          bus.rv_rd <= 1'b0;
          state     <= ST_CAP;
        end
        ST_CAP: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= bus.rv_rdata;
          bus.out_last  <= (off == LAST_OFF);
          state         <= ST_SEND;
        end
        ST_SEND: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
          if (off != LAST_OFF) begin
            off         <= off + 6'd1;
            bus.rv_rd   <= 1'b1;
            bus.rv_addr <= {page, off + 6'd1};
            state       <= ST_RD;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          // Fresh writes during the packet mean the game is active again: wait for quiet.
          if (found && !(wr_seen || written)) begin
            state <= ST_SCAN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gba_save_sync.sv
// Randomized bench for gba_save_sync: a page-level reference model predicts
// each packet from the dirty set and checks every streamed byte and handshake.
module tb_gba_save_sync;
  localparam int         Q     = 16;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic       clk = 1'b0, rst = 1'b0;
  logic       written = 1'b0, model = 1'b1, flush_now = 1'b0;
  logic [9:0] wr_block = '0;
  logic       busy, dirty_any;
  int         cyc = 0;
  bit         rnd_ready = 1'b0;

  gba_save_sync_if bus ();

  gba_save_sync #(.QUIET_CYCLES(Q), .HDR_MAGIC(MAGIC)) dut (
    .clk(clk), .rst(rst), .written(written), .wr_block(wr_block), .model(model),
    .flush_now(flush_now), .bus(bus), .busy(busy), .dirty_any(dirty_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b000};
  endfunction

  // EEPROM RV port: data valid only in the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.rv_rd) bus.rv_rdata <= pat(bus.rv_addr);
    else           bus.rv_rdata <= 8'($urandom);
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input bit [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model state
  bit [127:0] mbm, mbm_prev;
  bit         pw_v, fl_seen, fl_prev;
  bit [6:0]   pw_pg, cur_page;
  int         k = 0, last_w = -1000, lw_prev = -1000, pg, hdr_cyc, last_xfer;
  logic [7:0] exp_b;
  logic [7:0] pkt_log [66];
  logic [6:0] pages [$];
  int         hdrs [$];
  bit         p_valid, p_ready, p_last, p_busy, p_rd;
  logic [7:0] p_data;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      mbm = '0; mbm_prev = '0; pw_v = 0; fl_seen = 0; fl_prev = 0; k = 0;
      p_valid = 0; p_busy = 0; p_rd = 0; p_ready = 0; p_last = 0; p_data = '0;
    end else begin
      if (p_valid && !p_ready) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, p_data);
        chk("stall_last", bus.out_last, p_last);
      end
      if (p_rd) chk("rv_rd_pulse", bus.rv_rd, 0);
      // A new header appears the cycle after the page was chosen from the bitmap.
      if (bus.out_valid && !p_valid && k == 0) begin
        pg = lowest(mbm_prev);
        chk("scan_has_dirty", (pg >= 0) ? 1 : 0, 1);
        if (pg >= 0) begin
          if (!(pw_v && pw_pg == 7'(pg))) mbm[pg] = 1'b0;
          cur_page = 7'(pg);
          pages.push_back(cur_page);
          hdrs.push_back(cyc);
          hdr_cyc = cyc;
        end
        if (!p_busy) chk("quiet_before_flush", ((cyc - lw_prev >= Q + 2) || fl_prev) ? 1 : 0, 1);
        chk("busy_in_pkt", busy, 1);
      end
      chk("dirty_any", dirty_any, (mbm != 0) ? 1 : 0);
      if (bus.out_valid && bus.out_ready) begin
        if (k == 0)      exp_b = MAGIC;
        else if (k == 1) exp_b = {1'b0, cur_page};
        else             exp_b = pat({cur_page, 6'(k - 2)});
        chk("byte", bus.out_data, exp_b);
        chk("last", bus.out_last, (k == 65) ? 1 : 0);
        pkt_log[k] = bus.out_data;
        if (k == 65) begin k = 0; last_xfer = cyc; end
        else k++;
      end
      mbm_prev = mbm; lw_prev = last_w; fl_prev = fl_seen;
      pw_v  = written;
      pw_pg = model ? wr_block[9:3] : {4'b0, wr_block[5:3]};
      if (written) begin mbm[pw_pg] = 1'b1; last_w = cyc; fl_seen = 0; end
      if (flush_now) fl_seen = 1;
      p_valid = bus.out_valid; p_ready = bus.out_ready; p_data = bus.out_data;
      p_last = bus.out_last; p_busy = busy; p_rd = bus.rv_rd;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic wr(input logic [9:0] b, input logic m, output int t);
    @(posedge clk); #1;
    t = cyc; written = 1'b1; wr_block = b; model = m;
    @(posedge clk); #1;
    written = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic wait_k(input int kk, input string name);
    int n = 0;
    while (k < kk && n < 5000) begin @(negedge clk); n++; end
    chk(name, (n < 5000) ? 1 : 0, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(!busy && !dirty_any && k == 0 && !bus.out_valid) && n < 20000);
    chk({name, "_drain"}, (n < 20000) ? 1 : 0, 1);
    chk({name, "_model_empty"}, (mbm == 0) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t, f, n0;
  initial begin
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_rv_rd", bus.rv_rd, 0);
    chk("rst_rv_addr", bus.rv_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dirty_any", dirty_any, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; bus.out_ready = 1'b1;
    repeat (Q + 4) @(posedge clk);

    // Single page, exact flush timing and packet contents
    wr(10'h009, 1'b1, t);
    wait_cyc(t + Q + 1);
    chk("t1_no_hdr_at_scan", bus.out_valid, 0);
    chk("t1_idle_busy", busy, 0);
    @(negedge clk);
    chk("t1_hdr_valid", bus.out_valid, 1);
    chk("t1_hdr_data", bus.out_data, 8'hA5);
    chk("t1_busy", busy, 1);
    drain("t1");
    chk("t1_b0", pkt_log[0], 8'hA5);
    chk("t1_b1", pkt_log[1], 8'h01);
    chk("t1_b2", pkt_log[2], 8'h40);
    chk("t1_b65", pkt_log[65], 8'h7F);
    chk("t1_len", last_xfer - hdr_cyc, 193);

    // Two pages, lowest first, back to back
    n0 = pages.size();
    wr(10'h3F8, 1'b1, t);
    wr(10'h000, 1'b1, t);
    drain("t2");
    chk("t2_count", pages.size() - n0, 2);
    chk("t2_first", pages[n0], 7'h00);
    chk("t2_second", pages[n0 + 1], 7'h7F);
    chk("t2_gap", hdrs[n0 + 1] - hdrs[n0], 196);

    // Random writes with a randomly stalling consumer
    rnd_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      wr(10'($urandom), 1'($urandom_range(0, 1)), t);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    drain("t3");
    rnd_ready = 1'b0;
    @(posedge clk); #1 bus.out_ready = 1'b1;

    // Rewrite of the page in flight: finishes, then resent after quiet
    n0 = pages.size();
    wr(10'h050, 1'b1, t);
    wait_k(30, "t4_reach");
    wr(10'h050, 1'b1, t);
    drain("t4");
    chk("t4_count", pages.size() - n0, 2);
    chk("t4_first", pages[n0], 7'h0A);
    chk("t4_resent", pages[n0 + 1], 7'h0A);
    chk("t4_gap", hdrs[n0 + 1] - hdrs[n0], 197);

    // Write collides with SCAN of the same page
    n0 = pages.size();
    wr(10'h100, 1'b1, t);
    wait_cyc(t + Q);
    wr(10'h100, 1'b1, f);
    chk("t5_write_in_scan", f, t + Q + 1);
    @(negedge clk);
    chk("t5_hdr_valid", bus.out_valid, 1);
    chk("t5_dirty_kept", dirty_any, 1);
    drain("t5");
    chk("t5_count", pages.size() - n0, 2);
    chk("t5_resent", pages[n0 + 1], 7'h20);

    // Small EEPROM aliasing, then an early flush via flush_now
    wr(10'h3F8, 1'b0, t);
    drain("t6");
    chk("t6_page", pages[pages.size() - 1], 7'h07);
    wr(10'h012, 1'b1, t);
    repeat (3) @(posedge clk);
    #1 flush_now = 1'b1; f = cyc;
    @(posedge clk); #1 flush_now = 1'b0;
    @(negedge clk);
    chk("t6_flush_scan", bus.out_valid, 0);
    @(negedge clk);
    chk("t6_flush_hdr", bus.out_valid, 1);
    chk("t6_flush_cyc", cyc - f, 2);
    drain("t6b");

    // Reset mid-packet
    wr(10'h3C0, 1'b1, t);
    wr(10'h008, 1'b1, t);
    @(posedge clk); #1 flush_now = 1'b1;
    @(posedge clk); #1 flush_now = 1'b0;
    wait_k(20, "t7_reach");
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t7_valid", bus.out_valid, 0);
    chk("t7_data", bus.out_data, 0);
    chk("t7_last", bus.out_last, 0);
    chk("t7_rd", bus.rv_rd, 0);
    chk("t7_busy", busy, 0);
    chk("t7_dirty", dirty_any, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3 * Q) @(posedge clk);
    @(negedge clk);
    chk("t7_quiet_after", bus.out_valid, 0);
    chk("t7_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
